// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported memory: one access per cycle,
// round-robin or fixed priority on ties from IDLE, registered read data per port.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_wen,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_wen,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic [1:0]    dbg_state
);

    // Handshake: a port holds req with its wen/addr/wdata until it samples gnt
    // high; gnt is high only in the cycle the access is driven to memory, and
    // rvalid pulses in the following cycle for reads.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          wen_l_q, wen_l_d;
    logic [AW-1:0] addr_l_q, addr_l_d;
    logic [DW-1:0] wdata_l_q, wdata_l_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;
    logic          p0_rvalid_q, p0_rvalid_d;
    logic          p1_rvalid_q, p1_rvalid_d;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wen_l_d     = wen_l_q;
        addr_l_d    = addr_l_q;
        wdata_l_d   = wdata_l_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, last_q=1 means port 1 was served last, so port 0 goes next.
                if (p0_req && (!p1_req || FIXED_PRIO || last_q)) begin
                    state_d   = ACC0;
                    wen_l_d   = p0_wen;
                    addr_l_d  = p0_addr;
                    wdata_l_d = p0_wdata;
                end else if (p1_req) begin
                    state_d   = ACC1;
                    wen_l_d   = p1_wen;
                    addr_l_d  = p1_addr;
                    wdata_l_d = p1_wdata;
                end
            end
            ACC0: begin
                last_d = 1'b0;
                if (!wen_l_q) begin
                    p0_rdata_d  = mem_dout;
                    p0_rvalid_d = 1'b1;
                end
                // The served port's own req is ignored here: it is still high
                // only because the requester is just now seeing gnt.
                if (p1_req) begin
                    state_d   = ACC1;
                    wen_l_d   = p1_wen;
                    addr_l_d  = p1_addr;
                    wdata_l_d = p1_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC1: begin
                last_d = 1'b1;
                if (!wen_l_q) begin
                    p1_rdata_d  = mem_dout;
                    p1_rvalid_d = 1'b1;
                end
                if (p0_req) begin
                    state_d   = ACC0;
                    wen_l_d   = p0_wen;
                    addr_l_d  = p0_addr;
                    wdata_l_d = p0_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            wen_l_q     <= 1'b0;
            addr_l_q    <= '0;
            wdata_l_q   <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wen_l_q     <= wen_l_d;
            addr_l_q    <= addr_l_d;
            wdata_l_q   <= wdata_l_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
        end
    end

    // Reset gates the strobes combinationally so an in-flight write never reaches
    // memory at the negedge of the cycle in which reset is raised.
    assign p0_gnt    = (state_q == ACC0) && !reset;
    assign p1_gnt    = (state_q == ACC1) && !reset;
    assign mem_ren   = (state_q != IDLE) && !wen_l_q && !reset;
    assign mem_wen   = (state_q != IDLE) && wen_l_q && !reset;
    assign mem_addr  = addr_l_q;
    assign mem_din   = wdata_l_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign dbg_state = state_q;

endmodule
